pifo_calendar_v0_2: RTL and testbench

// - Parametrised successor of the v0.1 root calendar: sorted push-in/first-out queue of DEPTH entries
//   {rank, data}, smallest rank at head; the head is the scheduler's next buffer address.
// - Adds valid/ready handshakes, same-cycle insert+pop, FIFO tie-break, occupancy/empty/full, flush.
// - Sits between the rank-computation stage and the output-queue buffer manager.

---
 rtl/pifo_calendar_v0_2.sv | 112 +++++++++++
 tb/tb_pifo_calendar_v0_2.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pifo_calendar_v0_2.sv
// Sorted push-in/first-out calendar: smallest rank at entry 0, FIFO order among equal ranks.
// Optional debug read port enabled by defining PIFO_CPU_RD_EN.
module pifo_calendar_v0_2 #(
    parameter int DEPTH      = 64,
    parameter int IDX_WIDTH  = $clog2(DEPTH),
    parameter int RANK_WIDTH = 19,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  s_ins_valid,
    input  logic [RANK_WIDTH-1:0] s_ins_rank,
    input  logic [DATA_WIDTH-1:0] s_ins_data,
    output logic                  s_ins_ready,
    output logic                  m_pop_valid,
    output logic [RANK_WIDTH-1:0] m_pop_rank,
    output logic [DATA_WIDTH-1:0] m_pop_data,
    input  logic                  m_pop_ready,
    output logic [IDX_WIDTH:0]    occupancy,
    output logic                  empty,
    output logic                  full
`ifdef PIFO_CPU_RD_EN
    ,
    input  logic                             cpu_rd_valid,
    input  logic [IDX_WIDTH-1:0]             cpu_rd_addr,
    output logic                             cpu_rd_result_valid,
    output logic [RANK_WIDTH+DATA_WIDTH:0]   cpu_rd_result
`endif
);
    localparam int EW = 1 + RANK_WIDTH + DATA_WIDTH;

    // entry word = {v, rank, data}
    logic [DEPTH-1:0][EW-1:0] ent, ent_nxt;
    logic [DEPTH-1:0]         lt;
    logic [EW-1:0]            nw;
    logic [IDX_WIDTH:0]       occ;
    logic                     pop, ins;

    assign nw          = {1'b1, s_ins_rank, s_ins_data};
    assign pop         = ent[0][EW-1] & m_pop_ready;
    assign full        = (occ == (IDX_WIDTH+1)'(DEPTH));
    assign empty       = (occ == '0);
    assign s_ins_ready = ~full | pop;
    assign ins         = s_ins_valid & s_ins_ready;
    assign occupancy   = occ;
    assign m_pop_valid = ent[0][EW-1];
    assign m_pop_rank  = ent[0][EW-2 -: RANK_WIDTH];
    assign m_pop_data  = ent[0][DATA_WIDTH-1:0];

    // lt is a thermometer (set for all i >= p) because valid entries are contiguous and sorted,
    // so each lane decides its move from its own and its neighbours' lt bits only.
    for (genvar i = 0; i < DEPTH; i++) begin : g_lane
        logic [EW-1:0] up, dn;
        logic          prev_lt, ge_q;

        assign lt[i] = ~ent[i][EW-1] | (ent[i][EW-2 -: RANK_WIDTH] > s_ins_rank);

        if (i == DEPTH-1) begin : g_tail
            assign up   = '0;
            assign ge_q = 1'b1;
        end else begin : g_mid
            assign up   = ent[i+1];
            assign ge_q = lt[i+1];
        end

        if (i == 0) begin : g_head
            assign dn      = '0;
            assign prev_lt = 1'b0;
        end else begin : g_body
            assign dn      = ent[i-1];
            assign prev_lt = lt[i-1];
        end

        // ge_q: i >= max(p-1,0); the lane just below owns q when its ge_q (= lt[i]) is clear
        assign ent_nxt[i] = (ins & ~pop) ? (prev_lt ? dn : (lt[i] ? nw : ent[i])) :
                            (~ins & pop) ? up :
                            (ins & pop)  ? (~ge_q ? up : ((i == 0 || !lt[i]) ? nw : ent[i])) :
                                           ent[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent <= '0;
            occ <= '0;
        end else if (flush) begin
            ent <= '0;
            occ <= '0;
        end else begin
            ent <= ent_nxt;
            if (ins && !pop)
                occ <= occ + 1'b1;
            else if (pop && !ins)
                occ <= occ - 1'b1;
        end
    end

`ifdef PIFO_CPU_RD_EN
    // snapshot of the pre-update entry; out-of-range indices read as zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rd_result_valid <= 1'b0;
            cpu_rd_result       <= '0;
        end else begin
            cpu_rd_result_valid <= cpu_rd_valid;
            if (cpu_rd_valid)
                cpu_rd_result <= ({1'b0, cpu_rd_addr} < (IDX_WIDTH+1)'(DEPTH)) ? ent[cpu_rd_addr] : '0;
        end
    end
`endif

endmodule

// File: tb/tb_pifo_calendar_v0_2.sv
// Directed bench for pifo_calendar_v0_2 (DEPTH=8): vector table plus full/flush/reset/read sequences.
module tb_pifo_calendar_v0_2;
    localparam int DEPTH = 8;
    localparam int IW    = 3;
    localparam int RW    = 19;
    localparam int DW    = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          s_ins_valid = 1'b0;
    logic [RW-1:0] s_ins_rank = '0;
    logic [DW-1:0] s_ins_data = '0;
    logic          s_ins_ready;
    logic          m_pop_valid;
    logic [RW-1:0] m_pop_rank;
    logic [DW-1:0] m_pop_data;
    logic          m_pop_ready = 1'b0;
    logic [IW:0]   occupancy;
    logic          empty, full;
`ifdef PIFO_CPU_RD_EN
    logic             cpu_rd_valid = 1'b0;
    logic [IW-1:0]    cpu_rd_addr = '0;
    logic             cpu_rd_result_valid;
    logic [RW+DW:0]   cpu_rd_result;
`endif

    int checks = 0;
    int errors = 0;

    pifo_calendar_v0_2 #(.DEPTH(DEPTH), .IDX_WIDTH(IW), .RANK_WIDTH(RW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_ins_valid(s_ins_valid), .s_ins_rank(s_ins_rank), .s_ins_data(s_ins_data),
        .s_ins_ready(s_ins_ready),
        .m_pop_valid(m_pop_valid), .m_pop_rank(m_pop_rank), .m_pop_data(m_pop_data),
        .m_pop_ready(m_pop_ready),
        .occupancy(occupancy), .empty(empty), .full(full)
`ifdef PIFO_CPU_RD_EN
        , .cpu_rd_valid(cpu_rd_valid), .cpu_rd_addr(cpu_rd_addr),
        .cpu_rd_result_valid(cpu_rd_result_valid), .cpu_rd_result(cpu_rd_result)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic          iv;
        logic [RW-1:0] r;
        logic [DW-1:0] d;
        logic          pr;
        logic          erdy;
        logic          ev;
        logic [RW-1:0] er;
        logic [DW-1:0] ed;
        logic [IW:0]   eo;
    } vec_t;

    vec_t vt[18];

    function automatic vec_t mk(logic iv, int r, int d, logic pr, logic erdy,
                                logic ev, int er, int ed, int eo);
        vec_t v;
        v.iv = iv; v.r = RW'(r); v.d = DW'(d); v.pr = pr; v.erdy = erdy;
        v.ev = ev; v.er = RW'(er); v.ed = DW'(ed); v.eo = (IW+1)'(eo);
        return v;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic iv, int r, int d, logic pr);
        s_ins_valid = iv;
        s_ins_rank  = RW'(r);
        s_ins_data  = DW'(d);
        m_pop_ready = pr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ins, rank, data, pop_ready | ready(pre-edge), head valid, rank, data, occupancy (post-edge)
        vt[0]  = mk(1, 5, 'hA,  0, 1, 1, 5, 'hA,  1);
        vt[1]  = mk(1, 3, 'hB,  0, 1, 1, 3, 'hB,  2);
        vt[2]  = mk(1, 9, 'hC,  0, 1, 1, 3, 'hB,  3);
        vt[3]  = mk(0, 0, 0,    1, 1, 1, 5, 'hA,  2);
        vt[4]  = mk(0, 0, 0,    1, 1, 1, 9, 'hC,  1);
        vt[5]  = mk(0, 0, 0,    1, 1, 0, 0, 0,    0);
        vt[6]  = mk(1, 4, 'h1,  0, 1, 1, 4, 'h1,  1);
        vt[7]  = mk(1, 4, 'h2,  0, 1, 1, 4, 'h1,  2);
        vt[8]  = mk(0, 0, 0,    1, 1, 1, 4, 'h2,  1);
        vt[9]  = mk(0, 0, 0,    1, 1, 0, 0, 0,    0);
        vt[10] = mk(0, 0, 0,    1, 1, 0, 0, 0,    0);
        vt[11] = mk(1, 2, 'h20, 0, 1, 1, 2, 'h20, 1);
        vt[12] = mk(1, 6, 'h60, 0, 1, 1, 2, 'h20, 2);
        vt[13] = mk(1, 4, 'h40, 1, 1, 1, 4, 'h40, 2);
        vt[14] = mk(1, 1, 'h10, 1, 1, 1, 1, 'h10, 2);
        vt[15] = mk(0, 0, 0,    1, 1, 1, 6, 'h60, 1);
        vt[16] = mk(0, 0, 0,    1, 1, 0, 0, 0,    0);
        vt[17] = mk(1, 7, 'h70, 1, 1, 1, 7, 'h70, 1);

        #1;
        chk("rst_valid", 64'(m_pop_valid), 64'd0);
        chk("rst_rank",  64'(m_pop_rank),  64'd0);
        chk("rst_data",  64'(m_pop_data),  64'd0);
        chk("rst_occ",   64'(occupancy),   64'd0);
        chk("rst_empty", 64'(empty),       64'd1);
        chk("rst_full",  64'(full),        64'd0);
        chk("rst_ready", 64'(s_ins_ready), 64'd1);
`ifdef PIFO_CPU_RD_EN
        chk("rst_rd_rv",  64'(cpu_rd_result_valid), 64'd0);
        chk("rst_rd_res", 64'(cpu_rd_result),       64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(vt[k].iv, int'(vt[k].r), int'(vt[k].d), vt[k].pr);
            #1;
            chk($sformatf("v%0d_ready", k), 64'(s_ins_ready), 64'(vt[k].erdy));
            step();
            chk($sformatf("v%0d_valid", k), 64'(m_pop_valid), 64'(vt[k].ev));
            chk($sformatf("v%0d_rank", k),  64'(m_pop_rank),  64'(vt[k].er));
            chk($sformatf("v%0d_data", k),  64'(m_pop_data),  64'(vt[k].ed));
            chk($sformatf("v%0d_occ", k),   64'(occupancy),   64'(vt[k].eo));
            chk($sformatf("v%0d_empty", k), 64'(empty),       64'(vt[k].eo == 0));
        end
        @(negedge clk);
        drive(0, 0, 0, 1);
        step();
        chk("drain_occ", 64'(occupancy), 64'd0);

        // fill to DEPTH with ranks 10..17
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            drive(1, 10 + k, 'h100 + k, 0);
            step();
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_occ",  64'(occupancy), 64'(DEPTH));
        @(negedge clk);
        drive(1, 1, 'h77, 0);
        #1;
        chk("full_ready", 64'(s_ins_ready), 64'd0);
        step();
        chk("full_noins_occ",  64'(occupancy),  64'(DEPTH));
        chk("full_noins_rank", 64'(m_pop_rank), 64'd10);
        @(negedge clk);
        drive(1, 0, 'h55, 1);
        #1;
        chk("full_pop_ready", 64'(s_ins_ready), 64'd1);
        step();
        chk("full_swap_rank", 64'(m_pop_rank), 64'd0);
        chk("full_swap_data", 64'(m_pop_data), 64'h55);
        chk("full_swap_occ",  64'(occupancy),  64'(DEPTH));
        chk("full_swap_full", 64'(full),       64'd1);
        for (int k = 0; k < DEPTH; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 1);
            #1;
            chk($sformatf("drain%0d_data", k), 64'(m_pop_data), (k == 0) ? 64'h55 : 64'('h100 + k));
            step();
        end
        chk("drain_empty", 64'(empty), 64'd1);

        // flush with a simultaneous insert
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, k + 1, k + 1, 0);
            step();
        end
        chk("preflush_occ", 64'(occupancy), 64'd3);
        @(negedge clk);
        drive(1, 0, 'h99, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_empty", 64'(empty),       64'd1);
        chk("flush_occ",   64'(occupancy),   64'd0);
        chk("flush_valid", 64'(m_pop_valid), 64'd0);

        // async reset mid-stream, checked before any clock edge
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, 7 - k, 'h30 + k, 0);
            step();
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        chk("prerst_rank", 64'(m_pop_rank), 64'd5);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(m_pop_valid), 64'd0);
        chk("arst_rank",  64'(m_pop_rank),  64'd0);
        chk("arst_data",  64'(m_pop_data),  64'd0);
        chk("arst_occ",   64'(occupancy),   64'd0);
        chk("arst_empty", 64'(empty),       64'd1);
        @(negedge clk);
        rst = 1'b0;

`ifdef PIFO_CPU_RD_EN
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            case (k)
                0: drive(1, 5, 'hA, 0);
                1: drive(1, 3, 'hB, 0);
                default: drive(1, 9, 'hC, 0);
            endcase
            step();
        end
        @(negedge clk);
        drive(0, 0, 0, 0);
        cpu_rd_valid = 1'b1;
        cpu_rd_addr  = 3'd2;
        step();
        chk("rd2_rv",  64'(cpu_rd_result_valid), 64'd1);
        chk("rd2_res", 64'(cpu_rd_result), {32'd0, 1'b1, 19'd9, 12'hC});
        @(negedge clk);
        cpu_rd_addr = 3'd5;
        step();
        chk("rd5_rv",  64'(cpu_rd_result_valid), 64'd1);
        chk("rd5_res", 64'(cpu_rd_result), 64'd0);
        @(negedge clk);
        cpu_rd_valid = 1'b0;
        step();
        chk("rd_idle_rv", 64'(cpu_rd_result_valid), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
